address_sequencer: RTL and testbench
====================================

ADDRESS_SEQUENCER -- requirements
Module: address_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 48, width of generated address.
REQ-002 SHALL have parameter COUNT_WIDTH, default 16, width of beat and loop counters.
REQ-003 SHALL have port clock  input  1  single clock; all state changes on posedge clock.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  begin a sequence; sampled only in IDLE.
REQ-006 SHALL have port stop  input  1  abort sequence, return to IDLE.
REQ-007 SHALL have port loop_mode  input  1  0 = single pass, 1 = restart at base after last.
REQ-008 SHALL have port base_addr  input  ADDR_WIDTH  first address; sampled on start.
REQ-009 SHALL have port last_addr  input  ADDR_WIDTH  terminal address; sampled on start.
REQ-010 SHALL have port step  input  8  unsigned increment; sampled on start; 0 treated as 1.
REQ-011 SHALL have port load_en  input  1  jump request; honoured only in RUN.
REQ-012 SHALL have port load_addr  input  ADDR_WIDTH  jump target.
REQ-013 SHALL have port ready  input  1  consumer accepts current address when valid && ready.
REQ-014 SHALL have port address  output  ADDR_WIDTH  current address, registered.
REQ-015 SHALL have port valid  output  1  address is meaningful (high only in RUN).
REQ-016 SHALL have port busy  output  1  high in RUN.
REQ-017 SHALL have port done  output  1  one-cycle pulse on single-pass completion.
REQ-018 SHALL have port beat_count  output  COUNT_WIDTH  accepted beats since last start, saturating.
REQ-019 SHALL have port loop_count  output  COUNT_WIDTH  completed passes in loop mode, wrapping.

Function
REQ-020 SHALL implement FSM states IDLE, RUN, DONE; all outputs registered.
REQ-021 IDLE: start=1 -> RUN next cycle; address <= base_addr, valid=1, counters cleared, base/last/step latched.
REQ-022 RUN, valid && !ready: address, counters and state SHALL hold unchanged (stall).
REQ-023 RUN, accept (valid && ready): beat_count += 1, saturating at all-ones.
REQ-024 Accept, address >= last_addr (unsigned), loop_mode=0: -> DONE, valid drops next cycle.
REQ-025 Accept, address >= last_addr, loop_mode=1: address <= latched base, loop_count += 1, stay RUN.
REQ-026 Accept, not terminal: address <= address + step; if sum exceeds ADDR_WIDTH bits it SHALL be treated as terminal (REQ-024/025 apply) and SHALL NOT wrap.
REQ-027 RUN, load_en=1: address <= load_addr next cycle regardless of ready; beat_count increments only if that cycle was an accept.
REQ-028 Priority within a cycle: stop > load_en > accept/advance.
REQ-029 stop=1 in RUN or DONE: -> IDLE next cycle, valid=0, no done pulse; counters and address hold last value.
REQ-030 DONE: done=1 for exactly one cycle, then -> IDLE; start in DONE ignored.
REQ-031 start while RUN SHALL be ignored; loop_mode is sampled live each accept.
REQ-032 Latency: first valid address one cycle after start sampled; one address per accepted cycle thereafter.
REQ-033 base_addr > last_addr: first address accepted is terminal (single beat per pass).

Reset
REQ-034 reset_n=0 SHALL immediately force IDLE, address=0, valid=0, busy=0, done=0, beat_count=0, loop_count=0, latched base/last/step=0, regardless of clock.
REQ-035 Reset asserted mid-RUN SHALL abort without done pulse; after release block waits in IDLE for start.

Verification
REQ-036 base=0, last=6, step=1, loop_mode=0, ready=1, pulse start -> address 0,1,..,6 on consecutive cycles, done pulse one cycle after 6 accepted, beat_count=7.
REQ-037 Same setup, ready low for 3 cycles while address=3 -> address holds 3 for those cycles, sequence resumes 4..6, beat_count=7.
REQ-038 base=0x10, last=0x18, step=4, loop_mode=1 -> 0x10,0x14,0x18,0x10,...; loop_count increments per pass; no done.
REQ-039 base=2^48-8, last=2^48-1, step=5 -> addresses 2^48-8, 2^48-3, then done; no wrap to low addresses.
REQ-040 Mid-run load_en with load_addr=0x100 and stop asserted same cycle -> IDLE, valid=0, address unchanged, no done.
REQ-041 reset_n pulsed low between clock edges at address=4 -> all outputs zero immediately; later start restarts from base.

Source files
------------

// File: rtl/address_sequencer.sv
// Address sequencer: emits base..last by step, with looping, jumps and abort; first address 1 cycle after start.
// Backpressure: valid && !ready stalls address, counters and state; load_en and stop act regardless of ready.
module address_sequencer #(
    parameter int ADDR_WIDTH  = 48,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   loop_mode,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [ADDR_WIDTH-1:0]  last_addr,
    input  logic [7:0]             step,
    input  logic                   load_en,
    input  logic [ADDR_WIDTH-1:0]  load_addr,
    input  logic                   ready,
    output logic [ADDR_WIDTH-1:0]  address,
    output logic                   valid,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] beat_count,
    output logic [COUNT_WIDTH-1:0] loop_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 r_state;
    logic [ADDR_WIDTH-1:0]  r_address;
    logic [ADDR_WIDTH-1:0]  r_base;
    logic [ADDR_WIDTH-1:0]  r_last;
    logic [7:0]             r_step;
    logic                   r_valid;
    logic                   r_busy;
    logic                   r_done;
    logic [COUNT_WIDTH-1:0] r_beat;
    logic [COUNT_WIDTH-1:0] r_loop;

    logic [ADDR_WIDTH:0]    w_sum;
    logic                   w_terminal;
    logic                   w_accept;
    logic [COUNT_WIDTH-1:0] w_beat_inc;

    // The extra sum bit flags a carry out; such a step ends the pass instead of wrapping.
    assign w_sum      = {1'b0, r_address} + {{(ADDR_WIDTH-7){1'b0}}, r_step};
    assign w_terminal = (r_address >= r_last) || w_sum[ADDR_WIDTH];
    assign w_accept   = r_valid && ready;
    assign w_beat_inc = (&r_beat) ? r_beat : r_beat + COUNT_ONE;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_address <= '0;
            r_base    <= '0;
            r_last    <= '0;
            r_step    <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_beat    <= '0;
            r_loop    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state   <= RUN;
                        r_address <= base_addr;
                        r_base    <= base_addr;
                        r_last    <= last_addr;
                        r_step    <= (step == 8'd0) ? 8'd1 : step;
                        r_valid   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_beat    <= '0;
                        r_loop    <= '0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        if (w_accept) begin
                            r_beat <= w_beat_inc;
                        end
                        if (load_en) begin
                            r_address <= load_addr;
                        end else if (w_accept) begin
                            if (w_terminal && !loop_mode) begin
                                r_state <= DONE;
                                r_valid <= 1'b0;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else if (w_terminal) begin
                                r_address <= r_base;
                                r_loop    <= r_loop + COUNT_ONE;
                            end else begin
                                r_address <= w_sum[ADDR_WIDTH-1:0];
                            end
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign address    = r_address;
    assign valid      = r_valid;
    assign busy       = r_busy;
    assign done       = r_done;
    assign beat_count = r_beat;
    assign loop_count = r_loop;

endmodule

// File: tb/tb_address_sequencer.sv
// Self-checking bench for address_sequencer: expected addresses queued at start, popped on each accept.
module tb_address_sequencer;

    localparam int AW = 48;
    localparam int CW = 16;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          loop_mode = 1'b0;
    logic          load_en = 1'b0;
    logic          ready = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] last_addr = '0;
    logic [AW-1:0] load_addr = '0;
    logic [7:0]    step = 8'd0;

    logic [AW-1:0] address;
    logic          valid;
    logic          busy;
    logic          done;
    logic [CW-1:0] beat_count;
    logic [CW-1:0] loop_count;

    int checks = 0;
    int errors = 0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] exp_a;

    address_sequencer #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .stop       (stop),
        .loop_mode  (loop_mode),
        .base_addr  (base_addr),
        .last_addr  (last_addr),
        .step       (step),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .ready      (ready),
        .address    (address),
        .valid      (valid),
        .busy       (busy),
        .done       (done),
        .beat_count (beat_count),
        .loop_count (loop_count)
    );

    always #5 clock = ~clock;

    // Reference model: addresses of one or more passes, terminating on >= last or carry out.
    task automatic push_model(input logic [AW-1:0] b, input logic [AW-1:0] l,
                              input logic [7:0] s, input int passes);
        logic [AW:0] a;
        logic [AW:0] nxt;
        logic [7:0]  st;
        st = (s == 8'd0) ? 8'd1 : s;
        for (int p = 0; p < passes; p++) begin
            a = {1'b0, b};
            for (int k = 0; k < 4096; k++) begin
                exp_q.push_back(a[AW-1:0]);
                nxt = a + {41'd0, st};
                if (a[AW-1:0] >= l || nxt[AW]) break;
                a = nxt;
            end
        end
    endtask

    task automatic kick(input logic [AW-1:0] b, input logic [AW-1:0] l,
                        input logic [7:0] s, input logic lm);
        @(negedge clock);
        base_addr = b;
        last_addr = l;
        step      = s;
        loop_mode = lm;
        ready     = 1'b1;
        start     = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if (address !== '0 || valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            beat_count !== '0 || loop_count !== '0) begin
            errors++;
            $display("FAIL reset_state: addr=%h valid=%b busy=%b done=%b beat=%0d loop=%0d want all 0",
                     address, valid, busy, done, beat_count, loop_count);
        end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: valid=%b busy=%b want 0 0", valid, busy);
        end
    endtask

    task automatic test_single_pass;
        exp_q.delete();
        push_model(48'd0, 48'd6, 8'd1, 1);
        kick(48'd0, 48'd6, 8'd1, 1'b0);
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            @(negedge clock);
            if (c == 0) begin
                checks++;
                if (busy !== 1'b1 || valid !== 1'b1) begin
                    errors++;
                    $display("FAIL first_valid_latency: valid=%b busy=%b want 1 1", valid, busy);
                end
            end
            if (valid && ready) begin
                exp_a = exp_q.pop_front();
                checks++;
                if (address !== exp_a) begin
                    errors++;
                    $display("FAIL single_addr: got %h want %h", address, exp_a);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL single_timeout: %0d addresses outstanding want 0", exp_q.size());
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b1 || valid !== 1'b0 || beat_count !== 16'd7) begin
            errors++;
            $display("FAIL single_done: done=%b valid=%b beat=%0d want 1 0 7", done, valid, beat_count);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_one_cycle: done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_stall;
        bit stalled = 1'b0;
        int stall_left = 0;
        exp_q.delete();
        push_model(48'd0, 48'd6, 8'd1, 1);
        kick(48'd0, 48'd6, 8'd1, 1'b0);
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            @(negedge clock);
            if (valid) begin
                if (address == 48'd3 && !stalled) begin
                    stalled    = 1'b1;
                    ready      = 1'b0;
                    stall_left = 3;
                end else if (stall_left > 0) begin
                    checks++;
                    if (address !== 48'd3) begin
                        errors++;
                        $display("FAIL stall_hold: got %h want 3", address);
                    end
                    stall_left--;
                    if (stall_left == 0) ready = 1'b1;
                end
                if (ready) begin
                    exp_a = exp_q.pop_front();
                    checks++;
                    if (address !== exp_a) begin
                        errors++;
                        $display("FAIL stall_addr: got %h want %h", address, exp_a);
                    end
                end
            end
        end
        ready = 1'b1;
        @(negedge clock);
        checks++;
        if (exp_q.size() != 0 || done !== 1'b1 || beat_count !== 16'd7) begin
            errors++;
            $display("FAIL stall_done: left=%0d done=%b beat=%0d want 0 1 7", exp_q.size(), done, beat_count);
        end
        @(negedge clock);
    endtask

    task automatic test_loop;
        bit saw_done = 1'b0;
        exp_q.delete();
        push_model(48'h10, 48'h18, 8'd4, 3);
        kick(48'h10, 48'h18, 8'd4, 1'b1);
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            @(negedge clock);
            if (done) saw_done = 1'b1;
            if (valid && ready) begin
                exp_a = exp_q.pop_front();
                checks++;
                if (address !== exp_a) begin
                    errors++;
                    $display("FAIL loop_addr: got %h want %h", address, exp_a);
                end
            end
        end
        @(negedge clock);
        if (done) saw_done = 1'b1;
        checks++;
        if (exp_q.size() != 0 || loop_count !== 16'd3 || valid !== 1'b1 || address !== 48'h10) begin
            errors++;
            $display("FAIL loop_count: left=%0d loops=%0d valid=%b addr=%h want 0 3 1 10",
                     exp_q.size(), loop_count, valid, address);
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL loop_no_done: done seen=1 want 0");
        end
        stop = 1'b1;
        @(posedge clock);
        #1 stop = 1'b0;
        loop_mode = 1'b0;
        @(negedge clock);
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || loop_count !== 16'd3) begin
            errors++;
            $display("FAIL loop_stop: valid=%b busy=%b done=%b loops=%0d want 0 0 0 3",
                     valid, busy, done, loop_count);
        end
    endtask

    task automatic test_overflow;
        exp_q.delete();
        push_model(48'hFFFF_FFFF_FFF8, 48'hFFFF_FFFF_FFFF, 8'd5, 1);
        kick(48'hFFFF_FFFF_FFF8, 48'hFFFF_FFFF_FFFF, 8'd5, 1'b0);
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            @(negedge clock);
            if (valid && ready) begin
                exp_a = exp_q.pop_front();
                checks++;
                if (address !== exp_a) begin
                    errors++;
                    $display("FAIL ovf_addr: got %h want %h", address, exp_a);
                end
            end
        end
        @(negedge clock);
        checks++;
        if (exp_q.size() != 0 || done !== 1'b1 || address !== 48'hFFFF_FFFF_FFFD || beat_count !== 16'd2) begin
            errors++;
            $display("FAIL ovf_done: left=%0d done=%b addr=%h beat=%0d want 0 1 fffffffffffd 2",
                     exp_q.size(), done, address, beat_count);
        end
        @(negedge clock);
    endtask

    task automatic test_load;
        bit loaded = 1'b0;
        exp_q.delete();
        push_model(48'd0, 48'd2, 8'd1, 1);
        push_model(48'h40, 48'h42, 8'd1, 1);
        kick(48'd0, 48'h42, 8'd1, 1'b0);
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            @(negedge clock);
            load_en = 1'b0;
            if (valid && ready) begin
                exp_a = exp_q.pop_front();
                checks++;
                if (address !== exp_a) begin
                    errors++;
                    $display("FAIL load_addr: got %h want %h", address, exp_a);
                end
                if (exp_a == 48'd2 && !loaded) begin
                    loaded    = 1'b1;
                    load_en   = 1'b1;
                    load_addr = 48'h40;
                end
            end
        end
        load_en = 1'b0;
        @(negedge clock);
        checks++;
        if (exp_q.size() != 0 || done !== 1'b1 || beat_count !== 16'd6) begin
            errors++;
            $display("FAIL load_done: left=%0d done=%b beat=%0d want 0 1 6", exp_q.size(), done, beat_count);
        end
        @(negedge clock);
    endtask

    task automatic test_load_stop;
        bit found = 1'b0;
        kick(48'd0, 48'd100, 8'd1, 1'b0);
        for (int c = 0; c < 30 && !found; c++) begin
            @(negedge clock);
            if (valid && address == 48'd5) begin
                found     = 1'b1;
                load_en   = 1'b1;
                load_addr = 48'h100;
                stop      = 1'b1;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL load_stop_reach: address 5 seen=0 want 1");
        end
        @(posedge clock);
        #1;
        load_en = 1'b0;
        stop    = 1'b0;
        @(negedge clock);
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || address !== 48'd5 || beat_count !== 16'd5 || done !== 1'b0) begin
            errors++;
            $display("FAIL load_stop: valid=%b busy=%b addr=%h beat=%0d done=%b want 0 0 5 5 0",
                     valid, busy, address, beat_count, done);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b0 || address !== 48'd5) begin
            errors++;
            $display("FAIL load_stop_nodone: done=%b addr=%h want 0 5", done, address);
        end
    endtask

    task automatic test_base_above_last;
        exp_q.delete();
        push_model(48'd9, 48'd3, 8'd2, 1);
        kick(48'd9, 48'd3, 8'd2, 1'b0);
        @(negedge clock);
        exp_a = exp_q.pop_front();
        checks++;
        if (valid !== 1'b1 || address !== exp_a) begin
            errors++;
            $display("FAIL base_gt_last_addr: valid=%b addr=%h want 1 %h", valid, address, exp_a);
        end
        @(negedge clock);
        checks++;
        if (exp_q.size() != 0 || done !== 1'b1 || beat_count !== 16'd1) begin
            errors++;
            $display("FAIL base_gt_last_done: left=%0d done=%b beat=%0d want 0 1 1", exp_q.size(), done, beat_count);
        end
        @(negedge clock);
    endtask

    task automatic test_async_reset;
        bit found = 1'b0;
        kick(48'd0, 48'd10, 8'd1, 1'b0);
        for (int c = 0; c < 30 && !found; c++) begin
            @(negedge clock);
            if (valid && address == 48'd4) found = 1'b1;
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (!found || address !== '0 || valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            beat_count !== '0 || loop_count !== '0) begin
            errors++;
            $display("FAIL async_reset: found=%b addr=%h valid=%b busy=%b done=%b beat=%0d want 1 0 0 0 0 0",
                     found, address, valid, busy, done, beat_count);
        end
        #1 reset_n = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_wait_idle: valid=%b busy=%b done=%b want 0 0 0", valid, busy, done);
        end
        exp_q.delete();
        push_model(48'h20, 48'h22, 8'd0, 1);
        kick(48'h20, 48'h22, 8'd0, 1'b0);
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            @(negedge clock);
            if (valid && ready) begin
                exp_a = exp_q.pop_front();
                checks++;
                if (address !== exp_a) begin
                    errors++;
                    $display("FAIL restart_addr: got %h want %h", address, exp_a);
                end
            end
        end
        @(negedge clock);
        checks++;
        if (exp_q.size() != 0 || done !== 1'b1 || beat_count !== 16'd3) begin
            errors++;
            $display("FAIL restart_done: left=%0d done=%b beat=%0d want 0 1 3", exp_q.size(), done, beat_count);
        end
        @(negedge clock);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        test_reset();
        test_single_pass();
        test_stall();
        test_loop();
        test_overflow();
        test_load();
        test_load_stop();
        test_base_above_last();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
